// File: rtl/stimulus_debounce_if.sv
// stimulus_debounce_if: raw pin, clear and the conditioned outputs of one debounced stimulus
interface stimulus_debounce_if;
  logic       raw_in;
  logic       clear;
  logic       level_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] edge_count;
  logic       glitch;
  modport master(output raw_in, clear, input level_out, rise_pulse, fall_pulse, edge_count, glitch);
  modport slave(input raw_in, clear, output level_out, rise_pulse, fall_pulse, edge_count, glitch);
endinterface

// File: rtl/stimulus_debounce.sv
// stimulus_debounce: synchronise and debounce one raw pin into a clean level, edge strobes, press count and glitch flag
module stimulus_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter bit INVERT          = 1'b0
) (
  input logic               clk,
  input logic               reset,
  stimulus_debounce_if.slave bus
);
  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_t;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sync_q;
  logic             s, pending, toward, abort, accept, start;
  logic             level_q, rise_q, fall_q, glitch_q;
  logic [7:0]       count_q;
  assign s = sync_q[1] ^ INVERT;
  always_comb begin
    pending = state == S_RISE || state == S_FALL;
    toward  = state == S_RISE ? s : !s;
    abort   = pending && !toward;
    accept  = pending && toward && cnt == LIMIT;
    start   = (state == S_LOW && s) || (state == S_HIGH && !s);
  end
  // The reset value of the synchroniser is the inactive pin level, so s reads 0 during reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_q   <= {2{INVERT}};
      state    <= S_LOW;
      cnt      <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
      count_q  <= '0;
    end else begin
      sync_q   <= {sync_q[0], bus.raw_in};
      state    <= abort  ? (state == S_RISE ? S_LOW : S_HIGH) :
                  accept ? (state == S_RISE ? S_HIGH : S_LOW) :
                  start  ? (state == S_LOW ? S_RISE : S_FALL) : state;
      cnt      <= abort || accept ? '0 : start ? CNT_W'(1) : pending ? cnt + CNT_W'(1) : '0;
      level_q  <= accept ? state == S_RISE : level_q;
      rise_q   <= accept && state == S_RISE;
      fall_q   <= accept && state == S_FALL;
      glitch_q <= abort || (glitch_q && !bus.clear);
      count_q  <= bus.clear ? {7'd0, rise_q} : rise_q && count_q != 8'hFF ? count_q + 8'd1 : count_q;
    end
  assign bus.level_out  = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.glitch     = glitch_q;
  assign bus.edge_count = count_q;
endmodule

// File: tb/tb_stimulus_debounce.sv
// tb_stimulus_debounce: directed checks of timing, bounce rejection, saturation and reset abort; a second INVERT=1 instance sees the inverted pin
module tb_stimulus_debounce;
  logic clk = 1'b0;
  logic reset;
  int vectors = 0;
  int miscompares = 0;
  int rises = 0;
  int falls = 0;
  int r0;
  stimulus_debounce_if ifa();
  stimulus_debounce_if ifb();
  stimulus_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(4), .INVERT(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  stimulus_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(4), .INVERT(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
    rises += int'(ifa.rise_pulse);
    falls += int'(ifa.fall_pulse);
  endtask
  task automatic drive(input logic r, input logic c);
    ifa.raw_in = r;
    ifb.raw_in = !r;
    ifa.clear  = c;
    ifb.clear  = c;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0);
    repeat (2) tick;
    for (int i = 0; i < 4; i++) begin
      drive(i[0] == 1'b0, 1'b0);
      tick;
    end
    chk("rst_level", ifa.level_out, 0);
    chk("rst_rise", ifa.rise_pulse, 0);
    chk("rst_glitch", ifa.glitch, 0);
    chk("rst_count", ifa.edge_count, 0);
    chk("rst_level_inv", ifb.level_out, 0);
    drive(1'b0, 1'b0);
    reset = 1'b0;
    repeat (5) tick;
    chk("idle_level", ifa.level_out, 0);
    chk("idle_strobes", 16'(rises + falls), 0);
    chk("idle_level_inv", ifb.level_out, 0);
    drive(1'b1, 1'b0);
    repeat (6) tick;
    chk("press_e6_level", ifa.level_out, 0);
    chk("press_e6_level_inv", ifb.level_out, 0);
    tick;
    chk("press_e7_level", ifa.level_out, 1);
    chk("press_e7_rise", ifa.rise_pulse, 1);
    chk("press_e7_level_inv", ifb.level_out, 1);
    chk("press_e7_rise_inv", ifb.rise_pulse, 1);
    tick;
    chk("press_e8_rise", ifa.rise_pulse, 0);
    chk("press_count", ifa.edge_count, 1);
    chk("press_count_inv", ifb.edge_count, 1);
    repeat (2) tick;
    drive(1'b0, 1'b0);
    repeat (7) tick;
    chk("release_level", ifa.level_out, 0);
    chk("release_fall", ifa.fall_pulse, 1);
    tick;
    chk("release_fall_end", ifa.fall_pulse, 0);
    chk("release_strobes", 16'(rises * 16 + falls), 16'(1 * 16 + 1));
    drive(1'b0, 1'b1);
    tick;
    drive(1'b0, 1'b0);
    chk("clear_count", ifa.edge_count, 0);
    r0 = rises;
    drive(1'b1, 1'b0); tick;
    drive(1'b0, 1'b0); tick;
    drive(1'b1, 1'b0); tick;
    drive(1'b0, 1'b0); tick;
    chk("bounce_glitch_early", ifa.glitch, 1);
    drive(1'b1, 1'b0);
    repeat (6) tick;
    chk("bounce_level_before", ifa.level_out, 0);
    tick;
    chk("bounce_level_after", ifa.level_out, 1);
    tick;
    chk("bounce_count", ifa.edge_count, 1);
    chk("bounce_one_rise", 16'(rises - r0), 1);
    chk("bounce_glitch", ifa.glitch, 1);
    chk("bounce_glitch_inv", ifb.glitch, 1);
    drive(1'b0, 1'b0);
    repeat (8) tick;
    chk("bounce_release", ifa.level_out, 0);
    drive(1'b0, 1'b1);
    tick;
    drive(1'b0, 1'b0);
    chk("clear_glitch", ifa.glitch, 0);
    r0 = rises;
    drive(1'b1, 1'b0);
    repeat (3) tick;
    drive(1'b0, 1'b0);
    repeat (5) tick;
    chk("blip_level", ifa.level_out, 0);
    chk("blip_no_rise", 16'(rises - r0), 0);
    chk("blip_glitch", ifa.glitch, 1);
    drive(1'b0, 1'b1);
    tick;
    drive(1'b0, 1'b0);
    chk("blip_clear", ifa.glitch, 0);
    drive(1'b1, 1'b0);
    repeat (3) tick;
    drive(1'b0, 1'b0);
    repeat (2) tick;
    drive(1'b0, 1'b1);
    tick;
    drive(1'b0, 1'b0);
    chk("abort_beats_clear", ifa.glitch, 1);
    drive(1'b0, 1'b1);
    tick;
    drive(1'b0, 1'b0);
    chk("abort_then_clear", ifa.glitch, 0);
    r0 = rises;
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 1'b0);
      repeat (8) tick;
      drive(1'b0, 1'b0);
      repeat (8) tick;
      if (i == 253) chk("count_254", ifa.edge_count, 254);
      if (i == 254) chk("count_255", ifa.edge_count, 255);
    end
    chk("count_saturated", ifa.edge_count, 255);
    chk("count_rises", 16'(rises - r0), 260);
    drive(1'b1, 1'b0);
    repeat (7) tick;
    chk("coinc_rise", ifa.rise_pulse, 1);
    drive(1'b1, 1'b1);
    tick;
    drive(1'b1, 1'b0);
    chk("coinc_count", ifa.edge_count, 1);
    drive(1'b0, 1'b0);
    repeat (8) tick;
    r0 = rises;
    drive(1'b1, 1'b0);
    repeat (5) tick;
    reset = 1'b1;
    #1;
    chk("midrst_level", ifa.level_out, 0);
    chk("midrst_rise", ifa.rise_pulse, 0);
    chk("midrst_count", ifa.edge_count, 0);
    repeat (2) tick;
    reset = 1'b0;
    repeat (6) tick;
    chk("fresh_e6_level", ifa.level_out, 0);
    tick;
    chk("fresh_e7_level", ifa.level_out, 1);
    chk("fresh_e7_rise", ifa.rise_pulse, 1);
    chk("fresh_e7_level_inv", ifb.level_out, 1);
    chk("fresh_one_rise", 16'(rises - r0), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
